// File: rtl/hc595_pkg.sv
// Shared definitions for the 74HC595 display scan controller: FSM encoding,
// frame width and the frame-duration formula used for the rate sanity check.
package hc595_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_t;

    localparam int FRAME_BITS = 16;

    // One LOAD cycle, a low and a high half period per bit, and one latch half period.
    function automatic int frame_cycles(input int sclk_half);
        return 1 + (2 * FRAME_BITS + 1) * sclk_half;
    endfunction

endpackage

// File: rtl/hc595_scan_ctrl_tick.sv
// Free-running divider that emits a one-cycle tick every CLK_FREQ/TICK_HZ cycles.
module scan_tick #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int PERIOD = CLK_FREQ / TICK_HZ;
    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(PERIOD - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hc595_scan_ctrl.sv
// Multiplexed 7-segment scanner driving a pair of cascaded 74HC595s:
// each scan tick shifts one {segments, digit-select} frame MSB first and latches it.
module hc595_scan_ctrl
    import hc595_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int SCAN_HZ    = 1000,
    parameter int NUM_DIGITS = 4,
    parameter int SCLK_HALF  = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [8*NUM_DIGITS-1:0] seg_data,
    output logic                    ser,
    output logic                    sclk,
    output logic                    rclk,
    output logic                    busy,
    output logic [2:0]              digit_idx
);

    localparam int         HALF_W     = $clog2(SCLK_HALF + 1);
    localparam int         BIT_W      = $clog2(FRAME_BITS);
    localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

    if (CLK_FREQ / SCAN_HZ <= frame_cycles(SCLK_HALF)) begin : g_rate_check
        $error("hc595_scan_ctrl: scan period too short to fit one frame");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_digit_check
        $error("hc595_scan_ctrl: NUM_DIGITS must be 1..8");
    end
    if (SCLK_HALF < 1) begin : g_half_check
        $error("hc595_scan_ctrl: SCLK_HALF must be at least 1");
    end

    logic                  tick;
    state_t                state;
    state_t                state_next;
    logic [HALF_W-1:0]     half_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [FRAME_BITS-1:0] frame;
    logic [FRAME_BITS-1:0] frame_load;
    logic [2:0]            load_digit;
    logic [2:0]            captured_digit;
    logic [7:0]            seg_byte;
    logic [7:0]            sel_byte;
    logic                  half_done;
    logic                  last_bit;

    scan_tick #(
        .CLK_FREQ (CLK_FREQ),
        .TICK_HZ  (SCAN_HZ)
    ) u_scan_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign half_done  = (half_cnt == HALF_W'(SCLK_HALF - 1));
    assign last_bit   = (bit_cnt == BIT_W'(FRAME_BITS - 1));
    assign load_digit = (digit_idx == LAST_DIGIT) ? 3'd0 : digit_idx + 3'd1;

    // Frame as it will appear on the 595 outputs: segments in the far register, select in the near one.
    always_comb begin
        seg_byte = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (load_digit == 3'(i)) begin
                seg_byte = seg_data[8*i +: 8];
            end
        end
        sel_byte   = 8'd1 << load_digit;
        frame_load = (ACTIVE_LOW != 0) ? ~{seg_byte, sel_byte} : {seg_byte, sel_byte};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (tick && enable) state_next = LOAD;
            LOAD:     state_next = SHIFT_LO;
            SHIFT_LO: if (half_done) state_next = SHIFT_HI;
            SHIFT_HI: if (half_done) state_next = last_bit ? LATCH : SHIFT_LO;
            LATCH:    if (half_done) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            half_cnt       <= '0;
            bit_cnt        <= '0;
            frame          <= '0;
            captured_digit <= '0;
            digit_idx      <= LAST_DIGIT;
        end else begin
            state <= state_next;

            if (state_next != state) begin
                half_cnt <= '0;
            end else if (state == SHIFT_LO || state == SHIFT_HI || state == LATCH) begin
                half_cnt <= half_cnt + HALF_W'(1);
            end

            case (state)
                LOAD: begin
                    frame          <= frame_load;
                    captured_digit <= load_digit;
                    bit_cnt        <= '0;
                end
                SHIFT_HI: begin
                    if (half_done) begin
                        frame   <= {frame[FRAME_BITS-2:0], 1'b0};
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                LATCH: begin
                    if (half_done) begin
                        digit_idx <= captured_digit;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ser  = (state == SHIFT_LO || state == SHIFT_HI) ? frame[FRAME_BITS-1] : 1'b0;
    assign sclk = (state == SHIFT_HI);
    assign rclk = (state == LATCH);
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_hc595_scan_ctrl.sv
// Scoreboard bench for hc595_scan_ctrl: a cycle model predicts frames at scan ticks,
// a pin monitor reassembles the serial stream and compares on each latch pulse.
module tb_hc595_scan_ctrl;

    localparam int CLK_FREQ   = 1000;
    localparam int SCAN_HZ    = 10;
    localparam int NUM_DIGITS = 4;
    localparam int SCLK_HALF  = 1;
    localparam int PERIOD     = CLK_FREQ / SCAN_HZ;
    localparam int FRAME_LEN  = 1 + 33 * SCLK_HALF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] seg_data = 32'h0;
    logic [31:0] seg_data_al = 32'h000000FF;

    logic        ser, sclk, rclk, busy;
    logic [2:0]  digit_idx;
    logic        al_ser, al_sclk, al_rclk, al_busy;
    logic [2:0]  al_digit_idx;

    int          checks = 0;
    int          errors = 0;

    logic [18:0] exp_q[$];
    int          m_cnt = 0;
    int          m_left = 0;
    logic [2:0]  m_digit = 3'(NUM_DIGITS - 1);

    always #5 clk = ~clk;

    hc595_scan_ctrl #(
        .CLK_FREQ   (CLK_FREQ),
        .SCAN_HZ    (SCAN_HZ),
        .NUM_DIGITS (NUM_DIGITS),
        .SCLK_HALF  (SCLK_HALF),
        .ACTIVE_LOW (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .seg_data  (seg_data),
        .ser       (ser),
        .sclk      (sclk),
        .rclk      (rclk),
        .busy      (busy),
        .digit_idx (digit_idx)
    );

    hc595_scan_ctrl #(
        .CLK_FREQ   (CLK_FREQ),
        .SCAN_HZ    (SCAN_HZ),
        .NUM_DIGITS (NUM_DIGITS),
        .SCLK_HALF  (SCLK_HALF),
        .ACTIVE_LOW (1)
    ) dut_al (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .seg_data  (seg_data_al),
        .ser       (al_ser),
        .sclk      (al_sclk),
        .rclk      (al_rclk),
        .busy      (al_busy),
        .digit_idx (al_digit_idx)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic en, input logic [31:0] seg);
        @(negedge clk);
        #1;
        rst_n    = r;
        enable   = en;
        seg_data = seg;
    endtask

    task automatic waitBusyRise(input int limit, output int cycles);
        cycles = 0;
        while (cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (busy) break;
        end
        if (!busy) checkOutput("busy_rise_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitIdle(input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (busy) checkOutput("idle_timeout", 32'd1, 32'd0);
    endtask

    // Behavioural model: predicts when a frame starts and what it must contain.
    always @(posedge clk) begin : p_model
        logic       tk;
        logic [2:0] nd;
        logic [7:0] sb;
        logic [7:0] sel;
        if (!rst_n) begin
            m_cnt   = 0;
            m_left  = 0;
            m_digit = 3'(NUM_DIGITS - 1);
            exp_q.delete();
        end else begin
            tk    = (m_cnt == PERIOD - 1);
            m_cnt = tk ? 0 : m_cnt + 1;
            if (m_left > 0) begin
                m_left--;
            end else if (tk && enable) begin
                nd      = (m_digit == 3'(NUM_DIGITS - 1)) ? 3'd0 : m_digit + 3'd1;
                sb      = seg_data[8*nd +: 8];
                sel     = 8'(1 << nd);
                exp_q.push_back({nd, sb, sel});
                m_digit = nd;
                m_left  = FRAME_LEN;
            end
        end
    end

    // Pin monitor: rebuild the shifted word on sclk rises and score it on rclk.
    logic [15:0] col = '0;
    int          nbits = 0;
    int          busy_run = 0;
    logic        pend_valid = 1'b0;
    logic [2:0]  pend_digit = '0;
    logic        prev_sclk = 1'b0, prev_rclk = 1'b0, prev_busy = 1'b0;
    logic [15:0] al_col = '0;
    logic        al_done = 1'b0;
    logic        al_prev_sclk = 1'b0, al_prev_rclk = 1'b0;

    always @(negedge clk) begin : p_monitor
        logic [18:0] e;
        if (!rst_n) begin
            col        = '0;
            nbits      = 0;
            busy_run   = 0;
            pend_valid = 1'b0;
            if (!al_done) al_col = '0;
        end else begin
            checkOutput("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
            if (!busy) checkOutput("idle_pins", {29'd0, ser, sclk, rclk}, 32'd0);
            if (sclk && !prev_sclk) begin
                col = {col[14:0], ser};
                nbits++;
            end
            if (rclk && !prev_rclk) begin
                checkOutput("bit_count", nbits, 16);
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_rclk", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("frame", {16'd0, col}, {16'd0, e[15:0]});
                    pend_digit = e[18:16];
                    pend_valid = 1'b1;
                end
                col   = '0;
                nbits = 0;
            end
            if (busy) begin
                busy_run++;
            end else if (prev_busy) begin
                checkOutput("busy_len", busy_run, FRAME_LEN);
                busy_run = 0;
                if (pend_valid) begin
                    checkOutput("digit_idx", {29'd0, digit_idx}, {29'd0, pend_digit});
                    pend_valid = 1'b0;
                end
            end
            if (!al_done) begin
                if (al_sclk && !al_prev_sclk) al_col = {al_col[14:0], al_ser};
                if (al_rclk && !al_prev_rclk) begin
                    checkOutput("al_frame", {16'd0, al_col}, 32'h0000_00FE);
                    al_done = 1'b1;
                end
            end
        end
        prev_sclk    = sclk;
        prev_rclk    = rclk;
        prev_busy    = busy;
        al_prev_sclk = al_sclk;
        al_prev_rclk = al_rclk;
    end

    initial begin : p_watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : p_main
        int cyc;
        int busy_seen;

        repeat (3) @(negedge clk);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_pins", {29'd0, ser, sclk, rclk}, 32'd0);
        checkOutput("rst_digit", {29'd0, digit_idx}, 32'd3);

        applyStimulus(1'b1, 1'b1, 32'h12345678);
        waitBusyRise(200, cyc);
        checkOutput("first_tick_cycle", cyc, PERIOD);

        repeat (4) begin
            waitIdle(100);
            waitBusyRise(150, cyc);
        end
        waitIdle(100);
        checkOutput("wrap_digit", {29'd0, digit_idx}, 32'd0);

        waitBusyRise(150, cyc);
        repeat (14) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h12345678);
        waitIdle(100);
        busy_seen = 0;
        repeat (350) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        checkOutput("disabled_busy", busy_seen, 0);

        applyStimulus(1'b1, 1'b1, 32'hA1B2C3D4);
        waitBusyRise(150, cyc);
        waitIdle(100);

        waitBusyRise(150, cyc);
        repeat (11) @(negedge clk);
        applyStimulus(1'b0, 1'b1, 32'hA1B2C3D4);
        @(negedge clk);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_pins", {29'd0, ser, sclk, rclk}, 32'd0);
        checkOutput("abort_digit", {29'd0, digit_idx}, 32'd3);

        applyStimulus(1'b1, 1'b1, 32'h12345678);
        waitBusyRise(200, cyc);
        waitIdle(100);
        checkOutput("post_reset_digit", {29'd0, digit_idx}, 32'd0);

        repeat (5) @(negedge clk);
        checkOutput("queue_empty", exp_q.size(), 0);
        checkOutput("al_seen", {31'd0, al_done}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
